pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage register for the five-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a datapath bundle and a control bundle plus a valid bit.
//  Priority of operations: reset > flush > stall > load.
//  Stall is configurable: freeze the stage, or inject a bubble. Also counts bubbles and flags stall timeouts.
// PARAMETERS
//  DATA_W      128          datapath bundle width (PC, operands, imm, instr, ...)
//  CTRL_W      13           control bundle width (we_rf, wd_sel, ALU_mode, npc_op, dram_we)
//  DATA_RST    '0           out_data value after reset
//  CTRL_RST    '0           out_ctrl value after reset
//  CTRL_NOP    '0           control encoding of a bubble: no RF/DRAM write, NOP ALU
//  STALL_MODE  1            0 = HOLD (freeze all outputs); 1 = BUBBLE (emit NOP control, pass data)
//  CNT_W       16           width of the bubble counter
//  STALL_MAX   64           consecutive stall cycles before stall_timeout is raised (>=1)
// PORTS
//  clk            in   1        clock, rising edge
//  rst_n          in   1        asynchronous reset, active-low
//  stall          in   1        hazard-unit stall request for this stage
//  flush          in   1        branch/jump squash; overrides stall
//  in_valid       in   1        upstream stage holds a real instruction
//  in_data        in   DATA_W   upstream datapath bundle
//  in_ctrl        in   CTRL_W   upstream control bundle
//  out_valid      out  1        this stage holds a real instruction
//  out_data       out  DATA_W   registered datapath bundle
//  out_ctrl       out  CTRL_W   registered control bundle
//  bubble_cnt     out  CNT_W    bubbles emitted since reset, saturating
//  stall_timeout  out  1        sticky: stall held high for STALL_MAX consecutive cycles
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, out_data=DATA_RST, out_ctrl=CTRL_RST.
//   - bubble_cnt=0, stall_timeout=0, internal stall-run counter=0.
//  Latency: 1 cycle, in_* to out_*, on a load.
//  Per rising edge, first matching row applies:
//   - flush=1: out_valid<=0, out_ctrl<=CTRL_NOP, out_data holds. Counts as a bubble.
//   - stall=1, STALL_MODE=0: all out_* hold. Not a bubble.
//   - stall=1, STALL_MODE=1: out_valid<=0, out_ctrl<=CTRL_NOP, out_data<=in_data. Counts as a bubble.
//     Data passes so that PC/imm keep flowing for jump resolution.
//   - load: out_valid<=in_valid, out_data<=in_data, out_ctrl<=in_valid ? in_ctrl : CTRL_NOP.
//     A load with in_valid=0 counts as a bubble.
//  Invariant: out_valid=0 implies out_ctrl==CTRL_NOP, except directly after reset, when out_ctrl=CTRL_RST.
//  bubble_cnt:
//   - +1 on each cycle that counts as a bubble (see rows above).
//   - Saturates at 2**CNT_W-1 and never wraps.
//  Stall-run counter ($clog2(STALL_MAX+1) bits):
//   - Increments while stall=1 and flush=0; cleared when stall=0 or flush=1.
//   - When it reaches STALL_MAX, stall_timeout<=1 and stays 1 until reset.
//   - The counter itself saturates at STALL_MAX.
//  Simultaneous flush+stall:
//   - Flush wins; the stall-run counter clears.
//   - A stall still high next cycle restarts the count from 1.
//  Reset mid-stall or mid-flush: all state returns to reset values immediately, asynchronously.
//  All inputs are sampled only at the clock edge; no combinational path from input to output.
// STRUCTURE
//  Package pipe_pkg:
//   - CTRL_W and the field layout/offsets of the control bundle.
//   - CTRL_NOP encoding, built from NOP_ALU, npc_op=PC+4, we_rf=0, dram_we=0.
//   - Enum STALL_HOLD=0 / STALL_BUBBLE=1.
//  Sub-module sat_counter #(W, MAX): enable, clear, saturating count, at_max flag.
//   - Used twice: bubble_cnt (MAX=2**CNT_W-1) and the stall-run counter (MAX=STALL_MAX).
//  Remaining logic: one priority-encoded always block for the out_* registers.
// TESTING
//  1. Reset with in_valid=1, in_ctrl=13'h1A5, then release; one load -> out_ctrl=13'h1A5, out_valid=1, bubble_cnt=0.
//  2. STALL_MODE=1, stall for 3 cycles, in_data=32'h0000_0040 -> out_valid=0, out_ctrl=CTRL_NOP, out_data=0x40, bubble_cnt=3.
//  3. STALL_MODE=0, stall for 3 cycles with in_* changing -> out_* unchanged from the pre-stall load, bubble_cnt=0.
//  4. flush=1 and stall=1 in the same cycle, out_data=0x1234 -> out_valid=0, out_ctrl=CTRL_NOP, out_data stays 0x1234, bubble_cnt +1.
//  5. STALL_MAX=4: stall high 3 cycles -> stall_timeout=0; on the 4th -> 1; drop stall -> stays 1 until rst_n pulse.
//  6. CNT_W=3, 10 bubble cycles -> bubble_cnt=7 and holds; assert rst_n=0 mid-clock -> all outputs to reset values before the next edge.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline inter-stage registers: control bundle layout,
// the bubble (NOP) control encoding and the stall-mode selector.
package pipe_pkg;

    localparam int unsigned CTRL_W = 13;

    // Control bundle field layout, LSB first.
    localparam int unsigned WE_RF_LSB    = 0;
    localparam int unsigned WD_SEL_LSB   = 1;
    localparam int unsigned WD_SEL_W     = 2;
    localparam int unsigned ALU_MODE_LSB = 3;
    localparam int unsigned ALU_MODE_W   = 5;
    localparam int unsigned NPC_OP_LSB   = 8;
    localparam int unsigned NPC_OP_W     = 4;
    localparam int unsigned DRAM_WE_LSB  = 12;

    typedef enum logic [WD_SEL_W-1:0] {
        WD_ALU  = 2'd0,
        WD_DRAM = 2'd1,
        WD_PC4  = 2'd2,
        WD_IMM  = 2'd3
    } wd_sel_e;

    typedef enum logic [ALU_MODE_W-1:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_AND = 5'd3,
        ALU_OR  = 5'd4,
        ALU_XOR = 5'd5,
        ALU_SLL = 5'd6,
        ALU_SRL = 5'd7,
        ALU_SRA = 5'd8
    } alu_mode_e;

    typedef enum logic [NPC_OP_W-1:0] {
        NPC_PC4    = 4'd0,
        NPC_BRANCH = 4'd1,
        NPC_JAL    = 4'd2,
        NPC_JALR   = 4'd3
    } npc_op_e;

    typedef enum logic {
        STALL_HOLD   = 1'b0,
        STALL_BUBBLE = 1'b1
    } stall_mode_e;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic      we_rf,
        input wd_sel_e   wd_sel,
        input alu_mode_e alu_mode,
        input npc_op_e   npc_op,
        input logic      dram_we
    );
        logic [CTRL_W-1:0] c;
        c = '0;
        c[WE_RF_LSB]                 = we_rf;
        c[WD_SEL_LSB +: WD_SEL_W]     = wd_sel;
        c[ALU_MODE_LSB +: ALU_MODE_W] = alu_mode;
        c[NPC_OP_LSB +: NPC_OP_W]     = npc_op;
        c[DRAM_WE_LSB]               = dram_we;
        return c;
    endfunction

    // A bubble writes nothing and falls through to PC+4.
    localparam logic [CTRL_W-1:0] CTRL_NOP =
        pack_ctrl(1'b0, WD_ALU, ALU_NOP, NPC_PC4, 1'b0);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle and status signals of one pipeline stage register; master is the upstream/hazard
// side driving the stage, slave is the stage register itself.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) ();
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              stall_timeout;

    modport master (
        output stall, flush, in_valid, in_data, in_ctrl,
        input  out_valid, out_data, out_ctrl, bubble_cnt, stall_timeout
    );

    modport slave (
        input  stall, flush, in_valid, in_data, in_ctrl,
        output out_valid, out_data, out_ctrl, bubble_cnt, stall_timeout
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Up-counter that sticks at MAX; clear has priority over enable.
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);
    assign at_max = (cnt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush/stall priority, configurable stall behaviour
// (freeze or bubble), a saturating bubble counter and a sticky stall-timeout flag.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 128,
    parameter int unsigned       CTRL_W     = pipe_pkg::CTRL_W,
    parameter logic [DATA_W-1:0] DATA_RST   = '0,
    parameter logic [CTRL_W-1:0] CTRL_RST   = '0,
    parameter logic [CTRL_W-1:0] CTRL_NOP   = pipe_pkg::CTRL_NOP,
    parameter stall_mode_e       STALL_MODE = STALL_BUBBLE,
    parameter int unsigned       CNT_W      = 16,
    parameter int unsigned       STALL_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_stage_reg_if.slave   bus
);
    localparam int unsigned      RUN_W           = $clog2(STALL_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX         = RUN_W'(STALL_MAX);
    localparam logic [RUN_W-1:0] RUN_PRE         = RUN_W'(STALL_MAX - 1);
    localparam logic [CNT_W-1:0] BUB_MAX         = '1;
    localparam bit               BUBBLE_ON_STALL = (STALL_MODE == STALL_BUBBLE);

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CTRL_W-1:0] out_ctrl_q;

    logic              bubble_evt;
    logic              bub_en;
    logic              bub_sat;
    logic [CNT_W-1:0]  bub_cnt;

    logic              run_en;
    logic              run_clr;
    logic              run_at_max;
    logic              run_hit;
    logic [RUN_W-1:0]  run_cnt;
    logic              timeout_q;

    // Flush beats stall beats load; the bubble classification follows the same order.
    always_comb begin
        bubble_evt = 1'b0;
        if (bus.flush) begin
            bubble_evt = 1'b1;
        end else if (bus.stall) begin
            bubble_evt = BUBBLE_ON_STALL;
        end else begin
            bubble_evt = ~bus.in_valid;
        end
    end

    assign bub_en  = bubble_evt & ~bub_sat;
    assign run_en  = bus.stall & ~bus.flush;
    assign run_clr = ~run_en;

    // Raise the flag on the same edge the run length reaches STALL_MAX.
    assign run_hit = run_at_max | (run_en & (run_cnt == RUN_PRE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= DATA_RST;
            out_ctrl_q  <= CTRL_RST;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_NOP;
        end else if (bus.stall) begin
            if (BUBBLE_ON_STALL) begin
                out_valid_q <= 1'b0;
                out_ctrl_q  <= CTRL_NOP;
                out_data_q  <= bus.in_data;
            end
        end else begin
            out_valid_q <= bus.in_valid;
            out_data_q  <= bus.in_data;
            out_ctrl_q  <= bus.in_valid ? bus.in_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (run_hit) begin
            timeout_q <= 1'b1;
        end
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX (BUB_MAX)
    ) u_bubble_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (bub_en),
        .clr    (1'b0),
        .cnt    (bub_cnt),
        .at_max (bub_sat)
    );

    sat_counter #(
        .W   (RUN_W),
        .MAX (RUN_MAX)
    ) u_stall_run (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_en),
        .clr    (run_clr),
        .cnt    (run_cnt),
        .at_max (run_at_max)
    );

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_ctrl      = out_ctrl_q;
    assign bus.bubble_cnt    = bub_cnt;
    assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a bubble-mode instance (small counters) and a hold-mode instance
// share one stimulus stream; a rule-level model is checked every cycle plus literal spot checks.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [12:0] NOP       = pipe_pkg::CTRL_NOP;
    localparam logic [31:0] B_RST_D   = 32'hDEAD_BEEF;
    localparam logic [12:0] B_RST_C   = 13'h0ABC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [12:0] in_ctrl = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(13), .CNT_W(3))  bub_if ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(13), .CNT_W(16)) hold_if ();

    assign bub_if.stall     = stall;
    assign bub_if.flush     = flush;
    assign bub_if.in_valid  = in_valid;
    assign bub_if.in_data   = in_data;
    assign bub_if.in_ctrl   = in_ctrl;
    assign hold_if.stall    = stall;
    assign hold_if.flush    = flush;
    assign hold_if.in_valid = in_valid;
    assign hold_if.in_data  = in_data;
    assign hold_if.in_ctrl  = in_ctrl;

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(13), .DATA_RST(B_RST_D), .CTRL_RST(B_RST_C),
        .STALL_MODE(STALL_BUBBLE), .CNT_W(3), .STALL_MAX(4)
    ) u_bub (.clk(clk), .rst_n(rst_n), .bus(bub_if));

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(13), .STALL_MODE(STALL_HOLD)
    ) u_hold (.clk(clk), .rst_n(rst_n), .bus(hold_if));

    // Index 0 = bubble-mode instance, 1 = hold-mode instance.
    function automatic int cfg_max(input int d);
        return (d == 0) ? 4 : 64;
    endfunction
    function automatic int cfg_cap(input int d);
        return (d == 0) ? 7 : 65535;
    endfunction

    logic        m_valid   [2];
    logic [31:0] m_data    [2];
    logic [12:0] m_ctrl    [2];
    int          m_bubbles [2];
    int          m_run     [2];
    bit          m_tmo     [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_valid[d]   <= 1'b0;
                m_data[d]    <= (d == 0) ? B_RST_D : 32'h0;
                m_ctrl[d]    <= (d == 0) ? B_RST_C : 13'h0;
                m_bubbles[d] <= 0;
                m_run[d]     <= 0;
                m_tmo[d]     <= 1'b0;
            end else begin
                if (flush) begin
                    m_valid[d]   <= 1'b0;
                    m_ctrl[d]    <= NOP;
                    m_bubbles[d] <= m_bubbles[d] + 1;
                end else if (stall) begin
                    if (d == 0) begin
                        m_valid[d]   <= 1'b0;
                        m_ctrl[d]    <= NOP;
                        m_data[d]    <= in_data;
                        m_bubbles[d] <= m_bubbles[d] + 1;
                    end
                end else begin
                    m_valid[d] <= in_valid;
                    m_data[d]  <= in_data;
                    m_ctrl[d]  <= in_valid ? in_ctrl : NOP;
                    if (!in_valid) m_bubbles[d] <= m_bubbles[d] + 1;
                end
                m_run[d] <= (stall && !flush) ? m_run[d] + 1 : 0;
                if (stall && !flush && (m_run[d] + 1 >= cfg_max(d))) m_tmo[d] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_dut(input int d, input logic v, input logic [31:0] dat,
                              input logic [12:0] c, input int b, input logic t);
        if (d == 0) begin
            check("bub.out_valid", 32'(bub_if.out_valid), 32'(v));
            check("bub.out_data", bub_if.out_data, dat);
            check("bub.out_ctrl", 32'(bub_if.out_ctrl), 32'(c));
            check("bub.bubble_cnt", 32'(bub_if.bubble_cnt), 32'(b));
            check("bub.stall_timeout", 32'(bub_if.stall_timeout), 32'(t));
        end else begin
            check("hold.out_valid", 32'(hold_if.out_valid), 32'(v));
            check("hold.out_data", hold_if.out_data, dat);
            check("hold.out_ctrl", 32'(hold_if.out_ctrl), 32'(c));
            check("hold.bubble_cnt", 32'(hold_if.bubble_cnt), 32'(b));
            check("hold.stall_timeout", 32'(hold_if.stall_timeout), 32'(t));
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            expect_dut(0, m_valid[0], m_data[0], m_ctrl[0],
                       (m_bubbles[0] > cfg_cap(0)) ? cfg_cap(0) : m_bubbles[0], m_tmo[0]);
            expect_dut(1, m_valid[1], m_data[1], m_ctrl[1],
                       (m_bubbles[1] > cfg_cap(1)) ? cfg_cap(1) : m_bubbles[1], m_tmo[1]);
        end
    end

    task automatic cyc(input logic s, input logic f, input logic v,
                       input logic [31:0] dat, input logic [12:0] c);
        stall    = s;
        flush    = f;
        in_valid = v;
        in_data  = dat;
        in_ctrl  = c;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 13'h1A5;
        in_data  = 32'h11;
        repeat (2) @(negedge clk);
        expect_dut(0, 1'b0, B_RST_D, B_RST_C, 0, 1'b0);
        expect_dut(1, 1'b0, 32'h0, 13'h0, 0, 1'b0);
        rst_n = 1'b1;

        cyc(0, 0, 1, 32'h11, 13'h1A5);
        expect_dut(0, 1'b1, 32'h11, 13'h1A5, 0, 1'b0);
        expect_dut(1, 1'b1, 32'h11, 13'h1A5, 0, 1'b0);

        cyc(1, 0, 1, 32'h22, 13'h0F0);
        cyc(1, 0, 1, 32'h31, 13'h0F1);
        cyc(1, 0, 1, 32'h40, 13'h0F2);
        expect_dut(0, 1'b0, 32'h40, NOP, 3, 1'b0);
        expect_dut(1, 1'b1, 32'h11, 13'h1A5, 0, 1'b0);

        cyc(1, 0, 1, 32'h50, 13'h0F3);
        expect_dut(0, 1'b0, 32'h50, NOP, 4, 1'b1);
        expect_dut(1, 1'b1, 32'h11, 13'h1A5, 0, 1'b0);

        cyc(0, 0, 1, 32'h1234, 13'h055);
        expect_dut(0, 1'b1, 32'h1234, 13'h055, 4, 1'b1);
        expect_dut(1, 1'b1, 32'h1234, 13'h055, 0, 1'b0);

        cyc(1, 1, 1, 32'h5678, 13'h0AA);
        expect_dut(0, 1'b0, 32'h1234, NOP, 5, 1'b1);
        expect_dut(1, 1'b0, 32'h1234, NOP, 1, 1'b0);

        repeat (3) cyc(1, 0, 1, 32'h9, 13'h001);
        expect_dut(0, 1'b0, 32'h9, NOP, 7, 1'b1);
        expect_dut(1, 1'b0, 32'h1234, NOP, 1, 1'b0);

        cyc(0, 0, 0, 32'hAB, 13'h1FF);
        expect_dut(0, 1'b0, 32'hAB, NOP, 7, 1'b1);
        expect_dut(1, 1'b0, 32'hAB, NOP, 2, 1'b0);

        repeat (2) cyc(0, 1, 1, 32'hCD, 13'h001);
        expect_dut(0, 1'b0, 32'hAB, NOP, 7, 1'b1);
        expect_dut(1, 1'b0, 32'hAB, NOP, 4, 1'b0);

        // Hold-mode instance: 63 stalls stay below the limit, the 64th trips it.
        cyc(0, 0, 1, 32'h100, 13'h003);
        for (int i = 1; i <= 63; i++) cyc(1, 0, 1, 32'h100 + 32'(i), 13'h003);
        expect_dut(1, 1'b1, 32'h100, 13'h003, 4, 1'b0);
        cyc(1, 0, 1, 32'h200, 13'h003);
        expect_dut(1, 1'b1, 32'h100, 13'h003, 4, 1'b1);
        cyc(0, 0, 1, 32'h300, 13'h004);
        expect_dut(1, 1'b1, 32'h300, 13'h004, 4, 1'b1);

        // Asynchronous reset between edges while stalling.
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        expect_dut(0, 1'b0, B_RST_D, B_RST_C, 0, 1'b0);
        expect_dut(1, 1'b0, 32'h0, 13'h0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush in the middle of a stall run restarts the count.
        repeat (3) cyc(1, 0, 1, 32'h77, 13'h005);
        cyc(1, 1, 1, 32'h78, 13'h005);
        repeat (3) cyc(1, 0, 1, 32'h79, 13'h005);
        expect_dut(0, 1'b0, 32'h79, NOP, 7, 1'b0);
        cyc(1, 0, 1, 32'h7A, 13'h005);
        expect_dut(0, 1'b0, 32'h7A, NOP, 7, 1'b1);
        expect_dut(1, 1'b0, 32'h0, 13'h0, 1, 1'b0);

        cyc(0, 0, 1, 32'h81, 13'h006);
        cyc(0, 0, 0, 32'h82, 13'h007);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
